// File: rtl/mac_dot_unit.sv
// mac_dot_unit: streams LEN operand pairs over valid/ready and returns their
// dot product. Two-stage pipeline (multiply, then accumulate) with optional
// signed arithmetic, sticky overflow and saturation.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, len          begin a vector of len pairs (sampled in IDLE)
//   in_valid/in_ready   operand handshake, in_a/in_b operands
//   out_valid/out_ready result handshake, out_acc result, out_ovf overflow
//   busy                engine not idle
module mac_dot_unit #(
    parameter int unsigned N      = 16,
    parameter int unsigned GUARD  = 8,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned SAT    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N+GUARD-1:0]   out_acc,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int unsigned PW    = 2 * N;
    localparam int unsigned ACC_W = 2 * N + GUARD;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [PW-1:0]      p_q, p_d;
    logic               p_vld_q, p_vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               beat;
    logic [PW-1:0]      a_ext, b_ext;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W:0]     sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   sat_val;

    assign beat = in_valid & in_ready_q;

    // Operands widened to the product width; the low PW bits of an unsigned
    // multiply of the extended values equal the two's-complement product.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = PW'($signed(in_a));
            b_ext = PW'($signed(in_b));
            p_ext = ACC_W'($signed(p_q));
        end else begin
            a_ext = PW'(in_a);
            b_ext = PW'(in_b);
            p_ext = ACC_W'(p_q);
        end
    end

    // Accumulator adder with overflow detection and clamp value selection.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, p_ext};
        if (SIGNED != 0) begin
            add_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
            // Overflow direction follows the operand sign: negative clamps to min.
            sat_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_ovf = sum[ACC_W];
            sat_val = {ACC_W{1'b1}};
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        p_d         = p_q;
        p_vld_d     = 1'b0;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        // Stage 2: once saturated, the accumulator is frozen for the vector.
        if (p_vld_q && !((SAT != 0) && ovf_q)) begin
            if (add_ovf) begin
                ovf_d = 1'b1;
            end
            if (add_ovf && (SAT != 0)) begin
                acc_d = sat_val;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        state_d    = S_RUN;
                        count_d    = len;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (beat) begin
                    p_d     = a_ext * b_ext;
                    p_vld_d = 1'b1;
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) begin
                        state_d    = S_DRAIN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                state_d     = S_HOLD;
                out_valid_d = 1'b1;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_unit.sv
// Directed bench for mac_dot_unit: five configurations share one stimulus
// stream (16-bit unsigned/signed, 8-bit wrap/saturate unsigned, 8-bit signed
// saturate) and are compared against hand-computed results.
module tb_mac_dot_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_a, in_b;
    logic        out_ready;

    logic        rdy_u, rdy_s, rdy_w, rdy_t, rdy_ss;
    logic        vld_u, vld_s, vld_w, vld_t, vld_ss;
    logic        ovf_u, ovf_s, ovf_w, ovf_t, ovf_ss;
    logic        bsy_u, bsy_s, bsy_w, bsy_t, bsy_ss;
    logic [39:0] acc_u, acc_s;
    logic [15:0] acc_w, acc_t, acc_ss;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_dot_unit #(.N(16), .GUARD(8), .LEN_W(8), .SIGNED(0), .SAT(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(rdy_u), .in_a(in_a), .in_b(in_b), .out_valid(vld_u),
        .out_ready(out_ready), .out_acc(acc_u), .out_ovf(ovf_u), .busy(bsy_u));
    mac_dot_unit #(.N(16), .GUARD(8), .LEN_W(8), .SIGNED(1), .SAT(0)) dut_s (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(rdy_s), .in_a(in_a), .in_b(in_b), .out_valid(vld_s),
        .out_ready(out_ready), .out_acc(acc_s), .out_ovf(ovf_s), .busy(bsy_s));
    mac_dot_unit #(.N(8), .GUARD(0), .LEN_W(8), .SIGNED(0), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(rdy_w), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(vld_w),
        .out_ready(out_ready), .out_acc(acc_w), .out_ovf(ovf_w), .busy(bsy_w));
    mac_dot_unit #(.N(8), .GUARD(0), .LEN_W(8), .SIGNED(0), .SAT(1)) dut_t (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(rdy_t), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(vld_t),
        .out_ready(out_ready), .out_acc(acc_t), .out_ovf(ovf_t), .busy(bsy_t));
    mac_dot_unit #(.N(8), .GUARD(0), .LEN_W(8), .SIGNED(1), .SAT(1)) dut_ss (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(rdy_ss), .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(vld_ss),
        .out_ready(out_ready), .out_acc(acc_ss), .out_ovf(ovf_ss), .busy(bsy_ss));

    typedef struct {
        int               len;
        int               gap;
        int               hold;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [39:0]      e_u;
        logic [39:0]      e_s;
        logic [15:0]      e_w;
        logic             o_w;
        logic [15:0]      e_t;
        logic [15:0]      e_ss;
        logic             o_ss;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_vld(input string nm, input logic exp);
        chk({nm, " vld_u"},  40'(vld_u),  40'(exp));
        chk({nm, " vld_s"},  40'(vld_s),  40'(exp));
        chk({nm, " vld_w"},  40'(vld_w),  40'(exp));
        chk({nm, " vld_t"},  40'(vld_t),  40'(exp));
        chk({nm, " vld_ss"}, 40'(vld_ss), 40'(exp));
    endtask

    task automatic check_result(input string nm, input vec_t v);
        chk({nm, " acc_u"},  acc_u,        v.e_u);
        chk({nm, " ovf_u"},  40'(ovf_u),   40'd0);
        chk({nm, " acc_s"},  acc_s,        v.e_s);
        chk({nm, " ovf_s"},  40'(ovf_s),   40'd0);
        chk({nm, " acc_w"},  40'(acc_w),   40'(v.e_w));
        chk({nm, " ovf_w"},  40'(ovf_w),   40'(v.o_w));
        chk({nm, " acc_t"},  40'(acc_t),   40'(v.e_t));
        chk({nm, " ovf_t"},  40'(ovf_t),   40'(v.o_w));
        chk({nm, " acc_ss"}, 40'(acc_ss),  40'(v.e_ss));
        chk({nm, " ovf_ss"}, 40'(ovf_ss),  40'(v.o_ss));
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_all_vld({nm, " after accept"}, 1'b0);
        chk({nm, " busy idle"}, 40'(bsy_u), 40'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string nm;
        v  = vecs[i];
        nm = $sformatf("v%0d", i);
        start = 1'b1;
        len   = 8'(v.len);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " busy run"}, 40'(bsy_u), 40'd1);
        for (int k = 0; k < v.len; k++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
                chk({nm, " rdy stall"}, 40'(rdy_u), 40'd1);
            end
            in_valid = 1'b1;
            in_a     = v.a[k];
            in_b     = v.b[k];
            chk({nm, " rdy beat"}, 40'(rdy_u), 40'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        // One edge after the last beat: draining, result not yet valid.
        check_all_vld({nm, " drain"}, 1'b0);
        chk({nm, " rdy drain"}, 40'(rdy_u), 40'd0);
        @(negedge clk);
        check_all_vld({nm, " hold"}, 1'b1);
        check_result(nm, v);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({nm, " held vld"}, 40'(vld_u), 40'd1);
            chk({nm, " held rdy"}, 40'(rdy_u), 40'd0);
            chk({nm, " held acc"}, acc_u, v.e_u);
            chk({nm, " held acc_ss"}, 40'(acc_ss), 40'(v.e_ss));
        end
        handshake(nm);
    endtask

    initial begin
        vecs[0] = '{len:4, gap:0, hold:0,
                    a:{16'd4, 16'd3, 16'd2, 16'd1}, b:{16'd8, 16'd7, 16'd6, 16'd5},
                    e_u:40'd70, e_s:40'd70, e_w:16'd70, o_w:1'b0, e_t:16'd70,
                    e_ss:16'd70, o_ss:1'b0};
        vecs[1] = '{len:2, gap:0, hold:0,
                    a:{16'd0, 16'd0, 16'd2, 16'hFFFD}, b:{16'd0, 16'd0, 16'd4, 16'd5},
                    e_u:40'h4_FFF9, e_s:40'hFF_FFFF_FFF9, e_w:16'h04F9, o_w:1'b0,
                    e_t:16'h04F9, e_ss:16'hFFF9, o_ss:1'b0};
        vecs[2] = '{len:2, gap:0, hold:0,
                    a:{16'd0, 16'd0, 16'd255, 16'd255}, b:{16'd0, 16'd0, 16'd255, 16'd255},
                    e_u:40'h1_FC02, e_s:40'h1_FC02, e_w:16'hFC02, o_w:1'b1,
                    e_t:16'hFFFF, e_ss:16'd2, o_ss:1'b0};
        vecs[3] = '{len:1, gap:0, hold:0,
                    a:{16'd0, 16'd0, 16'd0, 16'd3}, b:{16'd0, 16'd0, 16'd0, 16'd3},
                    e_u:40'd9, e_s:40'd9, e_w:16'd9, o_w:1'b0, e_t:16'd9,
                    e_ss:16'd9, o_ss:1'b0};
        vecs[4] = '{len:3, gap:0, hold:0,
                    a:{16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    b:{16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                    e_u:40'h2_FFFA_0003, e_s:40'd3, e_w:16'hFA03, o_w:1'b1,
                    e_t:16'hFFFF, e_ss:16'd3, o_ss:1'b0};
        vecs[5] = '{len:2, gap:0, hold:0,
                    a:{16'd0, 16'd0, 16'h80, 16'h80}, b:{16'd0, 16'd0, 16'h80, 16'h80},
                    e_u:40'h8000, e_s:40'h8000, e_w:16'h8000, o_w:1'b0,
                    e_t:16'h8000, e_ss:16'h7FFF, o_ss:1'b1};
        vecs[6] = '{len:3, gap:0, hold:0,
                    a:{16'd0, 16'h80, 16'h80, 16'h80}, b:{16'd0, 16'h7F, 16'h7F, 16'h7F},
                    e_u:40'hBE80, e_s:40'hBE80, e_w:16'hBE80, o_w:1'b0,
                    e_t:16'hBE80, e_ss:16'h8000, o_ss:1'b1};
        vecs[7] = '{len:3, gap:2, hold:5,
                    a:{16'd0, 16'd30, 16'd20, 16'd10}, b:{16'd0, 16'd3, 16'd2, 16'd1},
                    e_u:40'd140, e_s:40'd140, e_w:16'd140, o_w:1'b0,
                    e_t:16'd140, e_ss:16'd140, o_ss:1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset vld",  40'(vld_u),  40'd0);
        chk("reset rdy",  40'(rdy_u),  40'd0);
        chk("reset busy", 40'(bsy_u),  40'd0);
        chk("reset acc",  acc_u,       40'd0);
        chk("reset ovf",  40'(ovf_u),  40'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Zero-length vector: result valid one cycle after start.
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0 vld",  40'(vld_u), 40'd1);
        chk("len0 acc",  acc_u,      40'd0);
        chk("len0 rdy",  40'(rdy_u), 40'd0);
        handshake("len0");

        // start pulsed while running is neither honoured nor queued.
        start = 1'b1;
        len   = 8'd2;
        @(negedge clk);
        len      = 8'd1;
        in_valid = 1'b1;
        in_a     = 16'd3;
        in_b     = 16'd3;
        @(negedge clk);
        start = 1'b0;
        in_a  = 16'd4;
        in_b  = 16'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("start_run drain vld", 40'(vld_u), 40'd0);
        @(negedge clk);
        chk("start_run vld", 40'(vld_u), 40'd1);
        chk("start_run acc", acc_u,      40'd25);
        handshake("start_run");
        repeat (2) @(negedge clk);
        chk("start_run no queue vld",  40'(vld_u), 40'd0);
        chk("start_run no queue busy", 40'(bsy_u), 40'd0);

        // Reset mid-vector discards partial state.
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = 16'd5;
        in_b     = 16'd5;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst partial acc", acc_u, 40'd50);
        rst = 1'b1;
        #1;
        chk("midrst vld",  40'(vld_u), 40'd0);
        chk("midrst acc",  acc_u,      40'd0);
        chk("midrst busy", 40'(bsy_u), 40'd0);
        chk("midrst rdy",  40'(rdy_u), 40'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
